// File: rtl/digdar_pulse_reader.sv
// Drains one captured radar pulse from the ADC A capture BRAM. The pulse
// leaves as a framed 32-bit valid/ready stream: three header words, then the
// packed sample words. A 2-entry skid buffer hides the 1-cycle BRAM latency,
// so the frame streams at one beat per cycle while downstream is ready.
module digdar_pulse_reader #(
    parameter int          RSZ   = 14,
    parameter logic [15:0] MAGIC = 16'hD16D
) (
    input  logic           adc_clk_i,
    input  logic           adc_rst_i,
    input  logic           start_i,
    input  logic           abort_i,
    input  logic [RSZ:0]   n_samples_i,
    input  logic [31:0]    trig_count_i,
    input  logic [31:0]    acp_count_i,
    output logic [RSZ-2:0] buf_raddr_o,
    input  logic [31:0]    buf_rdata_i,
    output logic [31:0]    m_tdata_o,
    output logic           m_tvalid_o,
    output logic           m_tlast_o,
    input  logic           m_tready_i,
    output logic           busy_o,
    output logic           done_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_DATA, ST_FIN} state_t;

    localparam logic [RSZ:0] N_MAX = {1'b1, {RSZ{1'b0}}};

    state_t state_q, state_d;

    // Start-time decode of the requested sample count.
    logic [RSZ:0]   n_clamped;
    logic [RSZ:0]   n_round;
    logic [RSZ-1:0] n_words;
    logic [31:0]    w0;

    // Skid buffer: entry 0 is the head presented on the stream; bit 32 is tlast.
    logic [32:0]    skid0_q, skid1_q;
    logic [1:0]     count_q;

    // Read-side bookkeeping.
    logic           rd_pending_q;  // a BRAM word lands on buf_rdata_i this cycle
    logic           rd_last_q;     // ...and it is the final data word
    logic           n_odd_q;
    logic           w2_pending_q;  // W2 not yet pushed into the skid buffer
    logic [RSZ-1:0] words_left_q;  // data words still to be read
    logic [RSZ-2:0] rd_addr_q;
    logic [31:0]    acp_q;
    logic [1:0]     hdr_pops_q;

    logic           accept_start, do_abort, pop, active;
    logic           push, push_hdr, issue;
    logic [2:0]     occ;
    logic [31:0]    rd_word;
    logic [32:0]    push_word;

    assign n_clamped = (n_samples_i > N_MAX) ? N_MAX : n_samples_i;
    assign n_round   = n_clamped + (RSZ+1)'(1);
    assign n_words   = n_round[RSZ:1];
    assign w0        = {MAGIC, 16'(n_clamped)};

    assign m_tvalid_o  = (count_q != 2'd0);
    assign m_tdata_o   = skid0_q[31:0];
    assign m_tlast_o   = m_tvalid_o && skid0_q[32];
    assign buf_raddr_o = rd_addr_q;
    assign busy_o      = (state_q == ST_HDR) || (state_q == ST_DATA);
    assign done_o      = (state_q == ST_FIN);

    assign pop    = m_tvalid_o && m_tready_i;
    assign active = busy_o && !abort_i;
    // Skid occupancy once this cycle's landing read and pop are accounted for;
    // a new word may only be scheduled when that leaves a free slot.
    assign occ      = 3'(count_q) + 3'(rd_pending_q) - 3'(pop);
    assign push_hdr = active && w2_pending_q && (occ < 3'd2);
    assign issue    = active && !w2_pending_q && (words_left_q != '0) && (occ < 3'd2);

    assign rd_word   = (rd_last_q && n_odd_q) ? {16'h0, buf_rdata_i[15:0]} : buf_rdata_i;
    assign push      = rd_pending_q || push_hdr;
    assign push_word = rd_pending_q ? {rd_last_q, rd_word} : {words_left_q == '0, acp_q};

    // State register.
    always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
        // NOTE: sequential state is assigned with <= so every flop samples
        // pre-edge values regardless of statement order.
        if (adc_rst_i) state_q <= ST_IDLE;
        else           state_q <= state_d;
    end

    // Next-state logic: frame sequencing, with abort overriding any busy state.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d      = state_q;
        accept_start = 1'b0;
        do_abort     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    accept_start = 1'b1;
                    state_d      = ST_HDR;
                end
            end
            ST_HDR: begin
                if (pop && skid0_q[32])              state_d = ST_FIN;
                else if (pop && hdr_pops_q == 2'd2)  state_d = ST_DATA;
            end
            ST_DATA: begin
                if (pop && skid0_q[32]) state_d = ST_FIN;
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (abort_i && state_q != ST_IDLE) begin
            do_abort = 1'b1;
            state_d  = ST_IDLE;
        end
    end

    // Datapath: header preload, BRAM read scheduling and the skid buffer.
    always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
        if (adc_rst_i) begin
            // NOTE: the skid payload is reset too because entry 0 drives
            // m_tdata_o directly, which must read 0 out of reset.
            skid0_q      <= '0;
            skid1_q      <= '0;
            count_q      <= 2'd0;
            rd_pending_q <= 1'b0;
            rd_last_q    <= 1'b0;
            n_odd_q      <= 1'b0;
            w2_pending_q <= 1'b0;
            words_left_q <= '0;
            rd_addr_q    <= '0;
            acp_q        <= '0;
            hdr_pops_q   <= 2'd0;
        end else if (accept_start) begin
            // W0 and W1 are known now, so they fill the skid immediately and
            // valid rises on the very next cycle.
            skid0_q      <= {1'b0, w0};
            skid1_q      <= {1'b0, trig_count_i};
            count_q      <= 2'd2;
            rd_pending_q <= 1'b0;
            rd_last_q    <= 1'b0;
            n_odd_q      <= n_clamped[0];
            w2_pending_q <= 1'b1;
            words_left_q <= n_words;
            rd_addr_q    <= '0;
            acp_q        <= acp_count_i;
            hdr_pops_q   <= 2'd0;
        end else if (do_abort) begin
            skid0_q      <= '0;
            skid1_q      <= '0;
            count_q      <= 2'd0;
            rd_pending_q <= 1'b0;
            w2_pending_q <= 1'b0;
            words_left_q <= '0;
        end else begin
            rd_pending_q <= issue;
            if (issue) begin
                words_left_q <= words_left_q - RSZ'(1);
                rd_last_q    <= (words_left_q == RSZ'(1));
                // Hold on the final address so it never runs past D-1 or wraps.
                if (words_left_q != RSZ'(1)) rd_addr_q <= rd_addr_q + (RSZ-1)'(1);
            end
            if (push_hdr) w2_pending_q <= 1'b0;
            if (pop && state_q == ST_HDR) hdr_pops_q <= hdr_pops_q + 2'd1;
            case ({push, pop})
                2'b11: begin
                    if (count_q == 2'd1) begin
                        skid0_q <= push_word;
                    end else begin
                        skid0_q <= skid1_q;
                        skid1_q <= push_word;
                    end
                end
                2'b01: begin
                    skid0_q <= skid1_q;
                    count_q <= count_q - 2'd1;
                end
                2'b10: begin
                    if (count_q == 2'd0) skid0_q <= push_word;
                    else                 skid1_q <= push_word;
                    count_q <= count_q + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_digdar_pulse_reader.sv
// Bench for digdar_pulse_reader: table of frames replayed through a BRAM
// model with an expected-beat queue, plus hand-written abort, busy-start,
// FIN-start and mid-frame reset sequences.
module tb_digdar_pulse_reader;

    localparam int RSZ = 14;
    localparam int NW  = 1 << (RSZ-1);

    logic           adc_clk_i = 1'b0;
    logic           adc_rst_i;
    logic           start_i, abort_i, m_tready_i;
    logic [RSZ:0]   n_samples_i;
    logic [31:0]    trig_count_i, acp_count_i, buf_rdata_i;
    logic [RSZ-2:0] buf_raddr_o;
    logic [31:0]    m_tdata_o;
    logic           m_tvalid_o, m_tlast_o, busy_o, done_o;

    digdar_pulse_reader #(.RSZ(RSZ), .MAGIC(16'hD16D)) dut (
        .adc_clk_i    (adc_clk_i),
        .adc_rst_i    (adc_rst_i),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .n_samples_i  (n_samples_i),
        .trig_count_i (trig_count_i),
        .acp_count_i  (acp_count_i),
        .buf_raddr_o  (buf_raddr_o),
        .buf_rdata_i  (buf_rdata_i),
        .m_tdata_o    (m_tdata_o),
        .m_tvalid_o   (m_tvalid_o),
        .m_tlast_o    (m_tlast_o),
        .m_tready_i   (m_tready_i),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 adc_clk_i = ~adc_clk_i;

    // Capture BRAM model: one cycle read latency.
    logic [31:0] mem [NW];
    always @(posedge adc_clk_i) buf_rdata_i <= mem[buf_raddr_o];

    typedef struct {
        logic [31:0] data;
        logic        last;
    } beat_t;

    typedef struct {
        int          n;
        logic [31:0] trig;
        logic [31:0] acp;
        int          pat;
        bit          rand_ready;
        bit          abort_at_start;
        int          exp_beats;
        logic [31:0] exp_w0;
        int          exp_max_addr;
    } vec_t;

    beat_t exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pat_word(input int pat, input int k);
        logic [15:0] kk;
        kk = 16'(k);
        if (pat == 0) return 32'h1000 + 32'(k);
        return {16'hA000 + kk, 16'h1000 + kk};
    endfunction

    task automatic fill(input int pat);
        for (int k = 0; k < NW; k++) mem[k] = pat_word(pat, k);
    endtask

    // Expected frame for a request of n samples.
    task automatic model(input int n, input logic [31:0] trig, input logic [31:0] acp, input int pat);
        int    nc;
        int    d;
        beat_t b;
        nc = (n > (1 << RSZ)) ? (1 << RSZ) : n;
        d  = (nc + 1) / 2;
        exp_q.delete();
        b.last = 1'b0;
        b.data = {16'hD16D, 16'(nc)}; exp_q.push_back(b);
        b.data = trig;                exp_q.push_back(b);
        b.data = acp; b.last = (d == 0); exp_q.push_back(b);
        for (int k = 0; k < d; k++) begin
            b.data = pat_word(pat, k);
            if (k == d - 1 && (nc % 2) == 1) b.data[31:16] = 16'h0;
            b.last = (k == d - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic check_zero(input string name);
        check(name, 64'({m_tdata_o, buf_raddr_o, m_tvalid_o, m_tlast_o, busy_o, done_o}), 64'd0);
    endtask

    // Issues one frame request and checks every beat against the queue.
    task automatic run_frame(input vec_t v, input string tag, input bit fin_start);
        int          cyc, beats, last_cyc, max_addr;
        bit          done_seen, prev_stall;
        logic [31:0] prev_data, w0;
        logic        prev_last;
        beat_t       b;
        model(v.n, v.trig, v.acp, v.pat);
        fill(v.pat);
        @(negedge adc_clk_i);
        n_samples_i  = (RSZ+1)'(v.n);
        trig_count_i = v.trig;
        acp_count_i  = v.acp;
        start_i      = 1'b1;
        abort_i      = v.abort_at_start;
        m_tready_i   = 1'b1;
        @(negedge adc_clk_i);
        start_i = 1'b0;
        abort_i = 1'b0;
        check({tag, " valid+busy after start"}, 64'({m_tvalid_o, busy_o}), 64'd3);
        cyc = 0; beats = 0; last_cyc = -1; max_addr = 0;
        done_seen = 1'b0; prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0; w0 = '0;
        while (!done_seen && cyc < 20000) begin
            m_tready_i = v.rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (prev_stall)
                check($sformatf("%s hold c%0d", tag, cyc), 64'({m_tvalid_o, m_tlast_o, m_tdata_o}),
                      64'({1'b1, prev_last, prev_data}));
            if (busy_o && int'(buf_raddr_o) > max_addr) max_addr = int'(buf_raddr_o);
            if (done_o) begin
                done_seen = 1'b1;
                check({tag, " done timing"}, 64'(cyc), 64'(last_cyc + 1));
                check({tag, " queue drained"}, 64'(exp_q.size()), 64'd0);
            end else if (m_tvalid_o && m_tready_i) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL %s extra beat: got 0x%0h, expected none", tag, m_tdata_o);
                end else begin
                    b = exp_q.pop_front();
                    check($sformatf("%s beat%0d data", tag, beats), 64'(m_tdata_o), 64'(b.data));
                    check($sformatf("%s beat%0d last", tag, beats), 64'(m_tlast_o), 64'(b.last));
                end
                if (beats == 0) w0 = m_tdata_o;
                if (!v.rand_ready && beats > 0)
                    check($sformatf("%s bubble at beat%0d", tag, beats), 64'(cyc), 64'(last_cyc + 1));
                last_cyc = cyc;
                beats++;
            end
            prev_stall = m_tvalid_o && !m_tready_i;
            prev_data  = m_tdata_o;
            prev_last  = m_tlast_o;
            if (!done_seen) begin
                @(negedge adc_clk_i);
                cyc++;
            end
        end
        check({tag, " done seen"}, 64'(done_seen), 64'd1);
        check({tag, " beat count"}, 64'(beats), 64'(v.exp_beats));
        check({tag, " W0"}, 64'(w0), 64'(v.exp_w0));
        check({tag, " max raddr"}, 64'(max_addr), 64'(v.exp_max_addr));
        if (!v.rand_ready) check({tag, " frame time"}, 64'(last_cyc), 64'(v.exp_beats - 1));
        start_i = fin_start;
        @(negedge adc_clk_i);
        start_i = 1'b0;
        check({tag, " idle after done"}, 64'({done_o, busy_o, m_tvalid_o}), 64'd0);
    endtask

    vec_t vecs[7];

    initial begin
        int          beats, stall_cnt;
        bit          aborted, prev_stall, saw_activity;
        logic [31:0] prev_data;
        logic        prev_last;
        beat_t       b;

        vecs[0] = '{6,     32'h11,       32'h22,       0, 1'b0, 1'b0, 6,    32'hD16D0006, 2};
        vecs[1] = '{5,     32'h12345678, 32'h9ABCDEF0, 1, 1'b0, 1'b1, 6,    32'hD16D0005, 2};
        vecs[2] = '{0,     32'h33,       32'h44,       1, 1'b0, 1'b0, 3,    32'hD16D0000, 0};
        vecs[3] = '{64,    32'h55,       32'h66,       1, 1'b1, 1'b0, 35,   32'hD16D0040, 31};
        vecs[4] = '{16384, 32'h77,       32'h88,       1, 1'b0, 1'b0, 8195, 32'hD16D4000, 8191};
        vecs[5] = '{20000, 32'h77,       32'h88,       1, 1'b0, 1'b0, 8195, 32'hD16D4000, 8191};
        vecs[6] = '{1,     32'h99,       32'hAA,       1, 1'b0, 1'b0, 4,    32'hD16D0001, 0};

        adc_rst_i = 1'b0; start_i = 1'b0; abort_i = 1'b0; m_tready_i = 1'b0;
        n_samples_i = '0; trig_count_i = '0; acp_count_i = '0;
        fill(0);
        #1 adc_rst_i = 1'b1;
        repeat (3) @(negedge adc_clk_i);
        check_zero("reset outputs");
        adc_rst_i = 1'b0;
        @(negedge adc_clk_i);
        check_zero("post-reset outputs");

        for (int i = 0; i < 7; i++) run_frame(vecs[i], $sformatf("vec%0d", i), i == 2);

        // Abort while stalled on the 4th data beat; a start while busy is ignored.
        model(16, 32'hAA, 32'hBB, 1);
        fill(1);
        @(negedge adc_clk_i);
        n_samples_i = 15'd16; trig_count_i = 32'hAA; acp_count_i = 32'hBB;
        start_i = 1'b1; m_tready_i = 1'b1;
        @(negedge adc_clk_i);
        start_i = 1'b0;
        beats = 0; stall_cnt = 0; aborted = 1'b0; prev_stall = 1'b0;
        prev_data = '0; prev_last = 1'b0;
        for (int cyc = 0; cyc < 60 && !aborted; cyc++) begin
            start_i = (cyc == 2);
            if (cyc == 2) n_samples_i = 15'd2;
            m_tready_i = (beats != 6);
            if (prev_stall)
                check("abort hold", 64'({m_tvalid_o, m_tlast_o, m_tdata_o}), 64'({1'b1, prev_last, prev_data}));
            if (m_tvalid_o && m_tready_i) begin
                b = exp_q.pop_front();
                check($sformatf("abort beat%0d data", beats), 64'(m_tdata_o), 64'(b.data));
                beats++;
            end else if (m_tvalid_o && beats == 6) begin
                stall_cnt++;
                if (stall_cnt == 1) check("abort stalled word", 64'(m_tdata_o), 64'(exp_q[0].data));
                if (stall_cnt == 3) begin
                    abort_i = 1'b1;
                    aborted = 1'b1;
                end
            end
            prev_stall = m_tvalid_o && !m_tready_i;
            prev_data  = m_tdata_o;
            prev_last  = m_tlast_o;
            @(negedge adc_clk_i);
        end
        abort_i = 1'b0; start_i = 1'b0; m_tready_i = 1'b1;
        check("abort reached", 64'(aborted), 64'd1);
        check("after abort", 64'({m_tvalid_o, busy_o, done_o}), 64'd0);
        saw_activity = 1'b0;
        repeat (4) begin
            @(negedge adc_clk_i);
            if (done_o || m_tvalid_o || busy_o) saw_activity = 1'b1;
        end
        check("quiet after abort", 64'(saw_activity), 64'd0);
        exp_q.delete();
        run_frame(vecs[0], "post-abort", 1'b0);

        // Asynchronous reset in the middle of a frame.
        fill(1);
        @(negedge adc_clk_i);
        n_samples_i = 15'd64; start_i = 1'b1; m_tready_i = 1'b1;
        @(negedge adc_clk_i);
        start_i = 1'b0;
        repeat (10) @(negedge adc_clk_i);
        check("mid-frame busy", 64'({busy_o, m_tvalid_o}), 64'd3);
        #2 adc_rst_i = 1'b1;
        #1 check_zero("mid-frame reset outputs");
        @(negedge adc_clk_i);
        adc_rst_i = 1'b0;
        @(negedge adc_clk_i);
        check_zero("after mid-frame reset");
        run_frame(vecs[6], "post-reset", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/digdar_pulse_reader.md
Name: digdar_pulse_reader

Overview:
- Drains one captured radar pulse from the 32-bit-wide ADC A capture BRAM (two 16-bit samples per word, earlier sample in the low half) after capture completes.
- Emits the pulse as a framed 32-bit valid/ready stream toward the host DMA path: a 3-word header, then the packed sample words.
- Acts as the reader side of the capture buffer; it sits alongside the scope capture block and shares its ADC clock domain.

Parameters:
- RSZ, 14, log2 of buffer capacity in 16-bit samples; the BRAM holds 2^(RSZ-1) 32-bit words.
- MAGIC, 16'hD16D, constant placed in the upper half of header word 0.

Ports:
- adc_clk_i  in  1  ADC clock; sole clock.
- adc_rst_i  in  1  reset, asynchronous, active-high.
- start_i  in  1  one-cycle request to drain a pulse; ignored while busy_o=1.
- abort_i  in  1  abandon the current frame.
- n_samples_i  in  RSZ+1  number of 16-bit samples to drain; latched on accepted start.
- trig_count_i  in  32  radar trigger count; latched on accepted start.
- acp_count_i  in  32  ACP count; latched on accepted start.
- buf_raddr_o  out  RSZ-1  BRAM word address.
- buf_rdata_i  in  32  BRAM data; valid exactly 1 cycle after buf_raddr_o is presented.
- m_tdata_o  out  32  stream data.
- m_tvalid_o  out  1  stream valid.
- m_tlast_o  out  1  marks the final beat of a frame.
- m_tready_i  in  1  downstream ready.
- busy_o  out  1  high from accepted start until done/abort.
- done_o  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset (async assert, sync release) drives every output to 0 and the state to IDLE.
- Start acceptance: start_i is accepted only in IDLE.
  - n_samples_i, trig_count_i and acp_count_i are latched that cycle.
  - n_samples_i > 2^RSZ is clamped to 2^RSZ.
  - busy_o rises the next cycle.
- Frame format:
  - W0 = {MAGIC, n_clamped[15:0]}
  - W1 = trig_count
  - W2 = acp_count
  - Then D = ceil(n/2) data words, read from word addresses 0 .. D-1 in order.
  - If n is odd, the final data word has its upper 16 bits forced to 0.
- m_tlast_o is asserted on the final beat: the last data word, or W2 when n = 0.
- States:
  - IDLE -> HDR on accepted start.
  - HDR emits W0..W2, one per handshake. The BRAM prefetch of word 0 is issued during HDR.
  - HDR -> DATA after W2 is accepted, if n > 0; otherwise HDR -> FIN.
  - DATA -> FIN when the tlast beat is accepted.
  - FIN pulses done_o for 1 cycle, drops busy_o, and returns to IDLE.
- Handshake rules:
  - A beat transfers when m_tvalid_o and m_tready_i are both high.
  - While m_tvalid_o=1 and m_tready_i=0, m_tdata_o and m_tlast_o hold stable and m_tvalid_o stays high.
  - m_tvalid_o rises the cycle after an accepted start.
- Throughput:
  - With m_tready_i held at 1, the frame must stream 1 beat per cycle with no bubbles, header through last data word.
  - This requires a 2-entry skid buffer to cover the 1-cycle BRAM latency.
  - Total frame time is D+3 cycles from first valid.
- Backpressure: BRAM reads are issued only when skid space exists. No word may be dropped or duplicated under any m_tready_i pattern.
- Address range: buf_raddr_o never exceeds D-1 and never wraps. With n = 2^RSZ, D = 2^(RSZ-1) and the last address is all ones.
- Abort:
  - abort_i in any non-IDLE state forces IDLE the next cycle.
  - m_tvalid_o, busy_o and the skid contents are cleared. done_o is not pulsed.
  - Dropping m_tvalid_o on abort is the one permitted exception to the hold rule.
  - abort_i in IDLE has no effect.
- Simultaneous events: start_i and abort_i high in the same IDLE cycle starts the frame (abort is ignored in IDLE). start_i in FIN is ignored.
- Mid-operation reset: an async reset during a frame immediately clears all outputs; no partial completion is signalled.

Test Plan:
- n=6, trig=0x11, acp=0x22, ready=1, BRAM word k = 0x1000+k: beats in consecutive cycles are
  - 0xD16D0006, 0x11, 0x22, 0x1000, 0x1001, 0x1002
  - tlast on 0x1002; done_o pulses 1 cycle after the tlast beat is accepted.
- n=5: third data word = {16'h0, low half of BRAM word 2}, with tlast on it; buf_raddr_o never exceeds 2.
- n=0: exactly 3 beats; W0 = 0xD16D0000, tlast on W2; no BRAM read address beyond 0 is consumed.
- n=64 with pseudo-random m_tready_i (50% duty): 35 beats are delivered, in order, none duplicated; data holds stable during every stall cycle.
- n=2^RSZ=16384 with ready=1: 8195 beats; the final address is 8191; W0 low half = 0x4000; n_samples_i=20000 produces an identical frame (clamped).
- Abort on the 4th data beat while stalled: the next cycle has tvalid=0 and busy=0 with no done_o. A new start then yields a correct full frame from W0. A start_i issued while busy is ignored.
